// File: rtl/onn_pkg.sv
// Shared constants and types for the neuron phase-loading path.
package onn_pkg;

  localparam int unsigned N_NEUR  = 15;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned FRAME_W = N_NEUR * PHASE_W;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_e;

endpackage

// File: rtl/phase_frame_fifo.sv
// Two-entry frame buffer; a push into a full buffer is dropped even if a pop happens in the same cycle.
module phase_frame_fifo #(
  parameter int unsigned W = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;
  logic         push_ok_c;
  logic         pop_ok_c;

  // Qualify requests against the registered occupancy.
  always_comb begin
    push_ok_c = push && (occ_q != 2'd2);
    pop_ok_c  = pop && (occ_q != 2'd0);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_ok_c) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok_c)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok_c, pop_ok_c})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_data;
  end

  assign head      = mem[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/phase_stream_serializer.sv
// Buffers whole phase frames and shifts them out MSB-first, one bit per clock, with sof/eof framing.
module phase_stream_serializer #(
  parameter int unsigned N_NEUR  = onn_pkg::N_NEUR,
  parameter int unsigned PHASE_W = onn_pkg::PHASE_W,
  parameter int unsigned GAP     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:N_NEUR*PHASE_W-1]     frame_in,
  input  logic                          hold,
  output logic                          ser_bit,
  output logic                          ser_valid,
  output logic                          sof,
  output logic                          eof,
  output logic [15:0]                   frames_sent
);

  import onn_pkg::*;

  localparam int unsigned FRM_W = N_NEUR * PHASE_W;
  localparam int unsigned BC_W  = (FRM_W > 1) ? $clog2(FRM_W) : 1;
  localparam int unsigned GC_W  = (GAP > 1) ? $clog2(GAP) : 1;

  ser_state_e       state_q, state_d;
  logic [FRM_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [GC_W-1:0]  gc_q, gc_d;
  logic [15:0]      frames_q, frames_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic [FRM_W-1:0] frame_vec;
  logic [FRM_W-1:0] fifo_head;
  logic [1:0]       fifo_occ;
  logic             fifo_empty_c;
  logic             push_c;
  logic             pop_c;
  logic             last_bit_c;

  // frame_in[0] lands in the MSB so shifting left emits the frame in index order.
  assign frame_vec    = frame_in;
  assign in_ready     = (fifo_occ != 2'd2);
  assign push_c       = in_valid && in_ready;
  assign fifo_empty_c = (fifo_occ == 2'd0);
  assign last_bit_c   = (bc_q == BC_W'(FRM_W - 1));

  phase_frame_fifo #(
    .W (FRM_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (frame_vec),
    .pop       (pop_c),
    .head      (fifo_head),
    .occupancy (fifo_occ)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bc_d        = bc_q;
    gc_d        = gc_q;
    frames_d    = frames_q;
    pop_c       = 1'b0;
    ser_bit_d   = 1'b0;
    ser_valid_d = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          sr_d    = fifo_head;
          bc_d    = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        ser_bit_d   = sr_q[FRM_W-1];
        ser_valid_d = 1'b1;
        sof_d       = (bc_q == '0);
        eof_d       = last_bit_c;
        if (!hold) begin
          if (last_bit_c) begin
            frames_d = frames_q + 16'd1;
            if (GAP > 0) begin
              gc_d    = GC_W'(GAP - 1);
              state_d = ST_GAP;
            end else if (!fifo_empty_c) begin
              pop_c = 1'b1;
              sr_d  = fifo_head;
              bc_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bc_d = bc_q + BC_W'(1);
            sr_d = sr_q << 1;
          end
        end
      end

      ST_GAP: begin
        if (gc_q == '0) begin
          if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            sr_d    = fifo_head;
            bc_d    = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gc_d = gc_q - GC_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bc_q        <= '0;
      gc_q        <= '0;
      frames_q    <= 16'd0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bc_q        <= bc_d;
      gc_q        <= gc_d;
      frames_q    <= frames_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign ser_bit     = ser_bit_q;
  assign ser_valid   = ser_valid_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign frames_sent = frames_q;

endmodule
